// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the escaped UART TX path between a
// single-byte command channel and a multi-byte data burst channel.
//
// Ports:
//   CLK_I, RST_I                     clock, sync active-high reset
//   CMD_VALID_I, CMD_I, CMD_READY_O  command channel
//   DATA_VALID_I, DATA_I,
//   DATA_LAST_I, DATA_READY_O        data burst channel
//   TX_READY_I                       escape stage ready
//   WRITE_O, DATA_SEND_O             data write to escape stage
//   WRITE_COMMAND_O, COMMAND_O       command write to escape stage
//
// Optional: define UART_TX_ARB_BURST_SLICE_EN to let one command
// cut into a burst after every MAX_BURST data bytes.

module uart_tx_arbiter #(
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_CMD_RUN = 4,
    parameter int MAX_BURST   = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       CMD_VALID_I,
    input  logic [7:0] CMD_I,
    output logic       CMD_READY_O,
    input  logic       DATA_VALID_I,
    input  logic [7:0] DATA_I,
    input  logic       DATA_LAST_I,
    output logic       DATA_READY_O,
    input  logic       TX_READY_I,
    output logic       WRITE_O,
    output logic [7:0] DATA_SEND_O,
    output logic       WRITE_COMMAND_O,
    output logic [7:0] COMMAND_O
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("GAP_CYCLES out of range 1..15");
    end
    if (MAX_CMD_RUN < 1 || MAX_CMD_RUN > 15) begin : g_bad_run
        $error("MAX_CMD_RUN out of range 1..15");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("MAX_BURST out of range 1..255");
    end

    localparam logic [3:0] GAP_L = 4'(GAP_CYCLES);
    localparam logic [3:0] RUN_L = 4'(MAX_CMD_RUN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic [3:0] run_q, run_d;
    // where the GAP state returns to once the counter expires
    logic       ret_q, ret_d;
    logic       grant_cmd, grant_data;
    logic       can_accept;

    logic       write_q, wcmd_q;
    logic [7:0] dsend_q, cmd_q;

`ifdef UART_TX_ARB_BURST_SLICE_EN
    localparam logic [7:0] SLICE_L = 8'(MAX_BURST);
    logic [7:0] bcnt_q, bcnt_d;
    logic       slice_due;
    assign slice_due = (bcnt_q >= SLICE_L);
`endif

    // state register
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            gap_q   <= '0;
            run_q   <= '0;
            ret_q   <= 1'b0;
`ifdef UART_TX_ARB_BURST_SLICE_EN
            bcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            run_q   <= run_d;
            ret_q   <= ret_d;
`ifdef UART_TX_ARB_BURST_SLICE_EN
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    // next-state and arbitration
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        run_d      = run_q;
        ret_d      = ret_q;
        grant_cmd  = 1'b0;
        grant_data = 1'b0;
`ifdef UART_TX_ARB_BURST_SLICE_EN
        bcnt_d     = bcnt_q;
`endif
        can_accept = !RST_I && TX_READY_I && (gap_q == 4'd0);

        unique case (state_q)
            IDLE: begin
                if (can_accept) begin
                    if (CMD_VALID_I && DATA_VALID_I
                        && run_q == RUN_L) begin
                        grant_data = 1'b1;
                    end else if (CMD_VALID_I) begin
                        grant_cmd = 1'b1;
                        if (!DATA_VALID_I)
                            run_d = 4'd0;
                        else if (run_q != RUN_L)
                            run_d = run_q + 4'd1;
                    end else if (DATA_VALID_I) begin
                        grant_data = 1'b1;
                    end
                end
            end
            BURST: begin
                if (can_accept) begin
`ifdef UART_TX_ARB_BURST_SLICE_EN
                    if (slice_due && CMD_VALID_I)
                        grant_cmd = 1'b1;
                    else if (DATA_VALID_I)
                        grant_data = 1'b1;
`else
                    if (DATA_VALID_I)
                        grant_data = 1'b1;
`endif
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    gap_d   = 4'd0;
                    state_d = ret_q ? BURST : IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = 4'd0;
            end
        endcase

        if (grant_data) begin
            run_d   = 4'd0;
            ret_d   = !DATA_LAST_I;
            state_d = GAP;
            gap_d   = GAP_L;
`ifdef UART_TX_ARB_BURST_SLICE_EN
            // a byte taken after an uncontested slice starts the next one
            if (DATA_LAST_I)
                bcnt_d = 8'd0;
            else if (slice_due)
                bcnt_d = 8'd1;
            else
                bcnt_d = bcnt_q + 8'd1;
`endif
        end

        if (grant_cmd) begin
            // a command taken inside a burst keeps the burst owner
            ret_d   = (state_q == BURST);
            state_d = GAP;
            gap_d   = GAP_L;
`ifdef UART_TX_ARB_BURST_SLICE_EN
            bcnt_d  = 8'd0;
`endif
        end
    end

    // issue registers: accepted byte appears one cycle later
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            write_q <= 1'b0;
            wcmd_q  <= 1'b0;
            dsend_q <= '0;
            cmd_q   <= '0;
        end else begin
            write_q <= grant_data;
            wcmd_q  <= grant_cmd;
            if (grant_data)
                dsend_q <= DATA_I;
            if (grant_cmd)
                cmd_q <= CMD_I;
        end
    end

    // outputs; strobes are masked so a byte in flight when reset
    // arrives is dropped rather than issued
    always_comb begin
        CMD_READY_O     = grant_cmd;
        DATA_READY_O    = grant_data;
        WRITE_O         = write_q && !RST_I;
        WRITE_COMMAND_O = wcmd_q && !RST_I;
        DATA_SEND_O     = dsend_q;
        COMMAND_O       = cmd_q;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the escaped UART transmit path between two requesters: a single-byte command channel and a multi-byte data burst channel.
- Sits between the protocol/TAP logic and the TX escape stage. Drives the escape stage's write, write-command, data and command inputs, paced by that stage's TX ready.
- Commands have priority. A data burst, once granted, is locked until its last byte. A starvation counter guarantees data progress under continuous command traffic.

Parameters:
- GAP_CYCLES, 2, idle cycles after each issued write before TX_READY_I is sampled again (covers registered ready lag downstream); legal range 1..15
- MAX_CMD_RUN, 4, consecutive command grants allowed while data is pending before data is forced; legal range 1..15
- MAX_BURST, 16, data bytes per burst slice (used only with the optional feature); legal range 1..255

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  synchronous, active-high reset
- CMD_VALID_I  in  1  command byte pending
- CMD_I  in  8  command byte
- CMD_READY_O  out  1  command accepted this cycle
- DATA_VALID_I  in  1  data byte pending
- DATA_I  in  8  data byte
- DATA_LAST_I  in  1  current data byte ends the burst
- DATA_READY_O  out  1  data byte accepted this cycle
- TX_READY_I  in  1  escape stage can take a write
- WRITE_O  out  1  one-cycle data write strobe to the escape stage
- DATA_SEND_O  out  8  data byte to the escape stage
- WRITE_COMMAND_O  out  1  one-cycle command write strobe to the escape stage
- COMMAND_O  out  8  command byte to the escape stage

Behaviour:
- Interface: one clock CLK_I. RST_I is synchronous and active-high.
- Reset values:
  - all outputs 0
  - state IDLE
  - gap counter 0
  - cmd-run counter 0
  - burst counter 0
  - any accepted but unissued byte is dropped
- States:
  - IDLE: no burst owner.
  - BURST: data channel owns the path.
  - GAP: post-write wait.
- Accept condition, evaluated combinationally in IDLE or BURST: TX_READY_I=1 and gap counter = 0. READY_O outputs are combinational from state, counters, valids and TX_READY_I. Only one READY_O is ever high in a cycle.
- IDLE arbitration, data forced: if CMD_VALID_I and DATA_VALID_I are both high and cmd-run = MAX_CMD_RUN, grant data.
- IDLE arbitration, command: otherwise, if CMD_VALID_I, grant the command and increment cmd-run (saturating) when DATA_VALID_I is high, else clear cmd-run.
- IDLE arbitration, data: otherwise, if DATA_VALID_I, grant data.
- Any data grant clears cmd-run.
- Data grant in IDLE: if DATA_LAST_I=0, the next non-gap state is BURST; if DATA_LAST_I=1, it is IDLE.
- BURST: only data is granted; commands wait. The burst ends when the accepted byte has DATA_LAST_I=1, and the next non-gap state is IDLE.
- Issue latency: byte accepted at cycle T is registered and presented at T+1.
  - Data: WRITE_O=1 with DATA_SEND_O = byte.
  - Command: WRITE_COMMAND_O=1 with COMMAND_O = byte.
  - Strobes are exactly 1 cycle. DATA_SEND_O/COMMAND_O hold their last value afterwards.
- Gap: at T+1 the gap counter loads GAP_CYCLES and state goes to GAP. It decrements each cycle and exits to IDLE or BURST at 0. Next accept is no earlier than T+1+GAP_CYCLES.
- Max throughput is one byte per GAP_CYCLES+1 cycles.
- Valid may drop without handshake; nothing is latched. A BURST with DATA_VALID_I low simply waits, with no timeout.
- TX_READY_I low holds IDLE/BURST with no accept. TX_READY_I is ignored during GAP.
- WRITE_O and WRITE_COMMAND_O are never high together.
- Reset asserted mid-burst or mid-gap returns to IDLE next cycle with no strobe.

Optional Feature:
- Macro: UART_TX_ARB_BURST_SLICE_EN
- Defined:
  - The burst counter counts accepted data bytes in BURST.
  - After MAX_BURST bytes without LAST, if CMD_VALID_I is high at the next accept opportunity, exactly one command is granted while burst ownership is retained. The counter is cleared and the burst resumes.
  - If no command is pending, the burst continues and the counter is cleared.
- Undefined: bursts are never interrupted and the burst counter is absent.

Test Plan:
1. Command only: CMD_VALID_I=1 with CMD_I=0x5A, TX_READY_I=1 -> CMD_READY_O high at T; WRITE_COMMAND_O=1 with COMMAND_O=0x5A at T+1; next accept no earlier than T+3 (GAP_CYCLES=2).
2. Burst lock: data 0x11, 0x22, 0x33 (LAST on 0x33), with CMD_VALID_I raised after 0x11 is accepted -> WRITE_O carries 0x11, 0x22, 0x33 in order, then the command strobe follows 0x33; no command strobe inside the burst.
3. Starvation: CMD_VALID_I and DATA_VALID_I held high continuously -> exactly 4 command strobes, then 1 data strobe, repeating.
4. Backpressure: TX_READY_I low for 10 cycles with CMD_VALID_I high -> no READY_O and no strobes; accept in the first cycle TX_READY_I returns high.
5. Reset mid-burst: assert RST_I one cycle after the first burst byte is accepted -> no WRITE_O strobe, all outputs 0, state IDLE; a new command is accepted on the first cycle after RST_I is released.
6. With UART_TX_ARB_BURST_SLICE_EN and MAX_BURST=4: a 10-byte burst with a command pending -> data strobes for bytes 1-4, one command strobe, bytes 5-8, one command strobe if still pending, bytes 9-10.
